event_encoder8_3: RTL and testbench
===================================

# event_encoder8_3

Sequential 8-to-3 priority event encoder: captures single-cycle event pulses on eight request lines, queues them as pending bits, and emits one 3-bit binary index per event over a valid/ready handshake. It is the inverse of the team's 3-to-8 one-hot decoder: an index emitted here, decoded by that block, reproduces the one-hot line that raised the event. It sits between per-source event strobes and any index-consuming logic, such as an interrupt handler or a dispatch FSM.

## Interface
- `LOW_FIRST`, default 1: 1 means the lowest set pending bit has highest priority; 0 means the highest set bit does.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_in` input 8: event pulses, sampled every rising edge; multiple bits may be set at once.
- `out_idx` output 3: binary index of the emitted event.
- `out_valid` output 1: `out_idx` holds a valid event.
- `out_ready` input 1: consumer accepts `out_idx` on an edge where `out_valid` && `out_ready`.
- `pending` output 8: registered mask of captured events not yet loaded into the output register.
- `overflow` output 1: one-cycle pulse when at least one event was dropped.
- `drop_cnt` output 8: saturating count of edges on which `overflow` was generated.

## Operation
- State machine with two states, tied to `out_valid`:
  - IDLE (`out_valid`=0)
  - HOLD (`out_valid`=1)
- `load = !out_valid || out_ready`, evaluated every edge.
- When `load` is true and `pending` != 0:
  - `out_idx` <= prio_enc(`pending`).
  - `out_valid` <= 1; the FSM goes to HOLD.
  - That bit is removed from `pending` on the same edge (`clr` = one-hot of the chosen index).
- When `load` is true and `pending` == 0: `out_valid` <= 0; the FSM goes to IDLE.
- When `load` is false (HOLD, `out_ready`=0): `out_idx` and `out_valid` hold; `clr` = 0.
- Pending update: `pending` <= (`pending` & ~`clr`) | `req_in`.
- Drop rule:
  - A `req_in` bit that is already set in (`pending` & ~`clr`) is a duplicate. It is merged and the event is lost.
  - `overflow` <= |(`req_in` & `pending` & ~`clr`).
  - `drop_cnt` increments by 1 per overflow edge and saturates at 8'hFF (no wrap).
- A `req_in` bit that equals the bit being cleared that edge re-sets pending. No overflow.
- A `req_in` bit whose index is currently held in `out_idx` simply becomes pending again (a second event). No overflow.
- Priority encoder:
  - Pure combinational.
  - Output is don't-care for input 0, but must be 0 in RTL so there is no X.
- Reset (async assert; deassert synchronised by the system): `pending`=0, `out_idx`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0, FSM=IDLE.
- Reset mid-handshake discards the held event and all pending events. Nothing is emitted after reset until a new `req_in` arrives.

## Timing
- Latency: `req_in` bit set before edge k → `pending` visible after edge k → `out_valid`/`out_idx` after edge k+1 (2 cycles) when the output register is free.
- Throughput: one event per cycle with `out_ready` held at 1.
- `out_idx` must not change while `out_valid`=1 and `out_ready`=0.
- `overflow` is registered and is asserted in the cycle after the offending `req_in` sample.
- `drop_cnt` updates on that same edge.
- All outputs are registered. There is no combinational path from `req_in` or `out_ready` to any output.

## Structure
- A shared package `event_enc_pkg` holds:
  - localparams `N_EV`=8 and `IDX_W`=3.
  - The `DROP_MAX`=8'hFF constant.
  - FSM state encoding: IDLE=1'b0, HOLD=1'b1.
- One sub-module: `prio_enc8`, the combinational 8→3 priority encoder with a `LOW_FIRST` parameter and an output `any` (= |input).
- The top module holds the pending register, the output register/FSM, overflow and `drop_cnt`.

## Test plan
- **Reset:** `rst`=1 with `req_in`=8'hFF → all outputs 0. After release, one `req_in`=8'h10 pulse → `out_valid`=1 and `out_idx`=3'd4 two edges later.
- **Multiple events, `LOW_FIRST`=1:** `req_in`=8'b1010_0100 for one cycle, `out_ready`=1 → `out_idx` sequence 2, 5, 7 on consecutive cycles, then `out_valid`=0. With `LOW_FIRST`=0 → 7, 5, 2.
- **Back-pressure:** `out_ready`=0 for 5 cycles with events 1 and 6 pending → `out_idx`=1 stable for all 5 cycles and `pending`=8'h40. Then `out_ready`=1 → 1 accepted, 6 follows next cycle.
- **Overflow:** `out_ready`=0, `req_in`=8'h08 twice, 2 cycles apart → second and later pulses beyond the held/pending slots raise `overflow` for 1 cycle and `drop_cnt`=1. Re-pulsing the bit being loaded on the same edge → no overflow.
- **Saturation:** 300 duplicate-drop cycles → `drop_cnt`=8'hFF and it holds there.
- **Round trip:** for each i=0..7, pulse the one-hot 1<<i → `out_idx`==i. Feeding `out_idx` through the team's 3-to-8 decoder reproduces 1<<i.

Source files
------------

// File: rtl/event_enc_pkg.sv
// Shared constants, FSM encoding and helpers for the 8-to-3 event encoder.
package event_enc_pkg;

    localparam int N_EV  = 8;
    localparam int IDX_W = 3;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // IDLE: output register empty; HOLD: output register holds an event.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot line for a binary index (same mapping as the 3-to-8 decoder).
    function automatic logic [N_EV-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_EV-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; index is 0 when no bit is set.
module prio_enc8
    import event_enc_pkg::*;
#(
    parameter int LOW_FIRST = 1
) (
    input  logic [N_EV-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign any = |req;

    // Scan so that the winning bit is the last one assigned.
    always_comb begin
        // NOTE: default first so every path assigns idx and no latch is inferred.
        idx = '0;
        for (int i = 0; i < N_EV; i++) begin
            if (LOW_FIRST != 0) begin
                if (req[N_EV-1-i]) idx = IDX_W'(N_EV - 1 - i);
            end else begin
                if (req[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/event_encoder8_3.sv
// Sequential 8-to-3 priority event encoder: captures event pulses into a
// pending mask and emits one index per event over a valid/ready handshake.
module event_encoder8_3
    import event_enc_pkg::*;
#(
    parameter int LOW_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EV-1:0]  req_in,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_EV-1:0]  pending,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    state_t           state;
    logic             load;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic [N_EV-1:0]  clr;
    logic [N_EV-1:0]  kept;
    logic [N_EV-1:0]  dup;

    prio_enc8 #(
        .LOW_FIRST(LOW_FIRST)
    ) u_prio (
        .req(pending),
        .idx(enc_idx),
        .any(enc_any)
    );

    assign out_valid = (state == HOLD);
    assign load      = !out_valid || out_ready;

    // Pick the bit leaving pending this edge and flag requests that collide.
    always_comb begin
        clr = '0;
        if (load && enc_any) clr = idx_to_onehot(enc_idx);
        kept = pending & ~clr;
        // A request for the bit being cleared, or for the held index, is a
        // fresh event; only a bit still pending after the clear is lost.
        dup  = req_in & kept;
    end

    // Pending mask, output register/FSM, overflow pulse and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_idx  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            pending  <= kept | req_in;
            overflow <= |dup;
            if (|dup && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
            if (load) begin
                if (enc_any) begin
                    out_idx <= enc_idx;
                    state   <= HOLD;
                end else begin
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_encoder8_3.sv
// Directed testbench for event_encoder8_3; one DUT per priority direction.
module tb_event_encoder8_3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = 8'h00;
    logic       out_ready = 1'b0;

    logic [2:0] lo_idx, hi_idx;
    logic       lo_valid, hi_valid;
    logic [7:0] lo_pending, hi_pending;
    logic       lo_ovf, hi_ovf;
    logic [7:0] lo_drop, hi_drop;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    event_encoder8_3 #(.LOW_FIRST(1)) dut_lo (
        .clk(clk), .rst(rst), .req_in(req_in),
        .out_idx(lo_idx), .out_valid(lo_valid), .out_ready(out_ready),
        .pending(lo_pending), .overflow(lo_ovf), .drop_cnt(lo_drop)
    );

    event_encoder8_3 #(.LOW_FIRST(0)) dut_hi (
        .clk(clk), .rst(rst), .req_in(req_in),
        .out_idx(hi_idx), .out_valid(hi_valid), .out_ready(out_ready),
        .pending(hi_pending), .overflow(hi_ovf), .drop_cnt(hi_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        req_in    = 8'h00;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 8'hFF; out_ready = 1'b0;
        step(); step();
        n_checks++; if (lo_pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %h exp 00", lo_pending); end
        n_checks++; if (lo_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", lo_valid); end
        n_checks++; if (lo_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", lo_idx); end
        n_checks++; if (lo_ovf !== 1'b0 || hi_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b/%b exp 0/0", lo_ovf, hi_ovf); end
        n_checks++; if (lo_drop !== 8'h00) begin n_fail++; $display("FAIL reset_drop got %h exp 00", lo_drop); end
        req_in = 8'h00;
        #3 rst = 1'b0;
        step();
        req_in = 8'h10;
        step();
        req_in = 8'h00;
        n_checks++; if (lo_pending !== 8'h10 || lo_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge_k pending=%h valid=%b exp 10/0", lo_pending, lo_valid); end
        step();
        n_checks++; if (lo_valid !== 1'b1 || lo_idx !== 3'd4) begin n_fail++; $display("FAIL lat_edge_k1 valid=%b idx=%0d exp 1/4", lo_valid, lo_idx); end
        drain();
    endtask

    task automatic test_reset_mid_handshake();
        out_ready = 1'b0; req_in = 8'h06;
        step();
        req_in = 8'h00;
        step();
        n_checks++; if (lo_valid !== 1'b1 || lo_idx !== 3'd1 || lo_pending !== 8'h04) begin n_fail++; $display("FAIL mid_hold valid=%b idx=%0d pending=%h exp 1/1/04", lo_valid, lo_idx, lo_pending); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (lo_valid !== 1'b0 || lo_pending !== 8'h00 || lo_idx !== 3'd0) begin n_fail++; $display("FAIL async_reset valid=%b pending=%h idx=%0d exp 0/00/0", lo_valid, lo_pending, lo_idx); end
        #2 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        n_checks++; if (lo_valid !== 1'b0 || hi_valid !== 1'b0 || lo_pending !== 8'h00) begin n_fail++; $display("FAIL post_reset_quiet valid=%b/%b pending=%h exp 0/0/00", lo_valid, hi_valid, lo_pending); end
        drain();
    endtask

    task automatic test_multi_events();
        logic [2:0] exp_lo [3];
        logic [2:0] exp_hi [3];
        exp_lo = '{3'd2, 3'd5, 3'd7};
        exp_hi = '{3'd7, 3'd5, 3'd2};
        out_ready = 1'b1; req_in = 8'b1010_0100;
        step();
        req_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (lo_valid !== 1'b1 || lo_idx !== exp_lo[i]) begin n_fail++; $display("FAIL multi_low[%0d] valid=%b idx=%0d exp 1/%0d", i, lo_valid, lo_idx, exp_lo[i]); end
            n_checks++; if (hi_valid !== 1'b1 || hi_idx !== exp_hi[i]) begin n_fail++; $display("FAIL multi_high[%0d] valid=%b idx=%0d exp 1/%0d", i, hi_valid, hi_idx, exp_hi[i]); end
            if (i == 0) begin
                n_checks++; if (lo_pending !== 8'hA0 || hi_pending !== 8'h24) begin n_fail++; $display("FAIL multi_pending got %h/%h exp a0/24", lo_pending, hi_pending); end
            end
        end
        step();
        n_checks++; if (lo_valid !== 1'b0 || hi_valid !== 1'b0) begin n_fail++; $display("FAIL multi_end valid=%b/%b exp 0/0", lo_valid, hi_valid); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; req_in = 8'h42;
        step();
        req_in = 8'h00;
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++; if (lo_valid !== 1'b1 || lo_idx !== 3'd1 || lo_pending !== 8'h40) begin n_fail++; $display("FAIL bp_hold[%0d] valid=%b idx=%0d pending=%h exp 1/1/40", c, lo_valid, lo_idx, lo_pending); end
        end
        out_ready = 1'b1;
        step();
        n_checks++; if (lo_valid !== 1'b1 || lo_idx !== 3'd6 || lo_pending !== 8'h00) begin n_fail++; $display("FAIL bp_next valid=%b idx=%0d pending=%h exp 1/6/00", lo_valid, lo_idx, lo_pending); end
        step();
        n_checks++; if (lo_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end valid=%b exp 0", lo_valid); end
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0; req_in = 8'h08;
        step();
        req_in = 8'h00;
        step();
        req_in = 8'h08;
        step();
        n_checks++; if (lo_ovf !== 1'b0 || lo_pending !== 8'h08 || lo_idx !== 3'd3) begin n_fail++; $display("FAIL ovf_held_repulse ovf=%b pending=%h idx=%0d exp 0/08/3", lo_ovf, lo_pending, lo_idx); end
        req_in = 8'h00;
        step();
        req_in = 8'h08;
        step();
        n_checks++; if (lo_ovf !== 1'b1 || lo_drop !== 8'd1) begin n_fail++; $display("FAIL ovf_dup ovf=%b drop=%0d exp 1/1", lo_ovf, lo_drop); end
        req_in = 8'h00;
        step();
        n_checks++; if (lo_ovf !== 1'b0 || lo_drop !== 8'd1) begin n_fail++; $display("FAIL ovf_pulse_end ovf=%b drop=%0d exp 0/1", lo_ovf, lo_drop); end
        out_ready = 1'b1; req_in = 8'h08;
        step();
        req_in = 8'h00;
        n_checks++; if (lo_ovf !== 1'b0 || lo_pending !== 8'h08 || lo_valid !== 1'b1 || lo_idx !== 3'd3 || lo_drop !== 8'd1) begin n_fail++; $display("FAIL ovf_clr_same_edge ovf=%b pending=%h valid=%b idx=%0d drop=%0d exp 0/08/1/3/1", lo_ovf, lo_pending, lo_valid, lo_idx, lo_drop); end
        step();
        n_checks++; if (lo_valid !== 1'b1 || lo_idx !== 3'd3 || lo_pending !== 8'h00) begin n_fail++; $display("FAIL ovf_reemit valid=%b idx=%0d pending=%h exp 1/3/00", lo_valid, lo_idx, lo_pending); end
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b0; req_in = 8'h01;
        repeat (300) step();
        n_checks++; if (lo_drop !== 8'hFF || hi_drop !== 8'hFF) begin n_fail++; $display("FAIL sat_reach drop=%h/%h exp ff/ff", lo_drop, hi_drop); end
        n_checks++; if (lo_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf ovf=%b exp 1", lo_ovf); end
        repeat (3) step();
        n_checks++; if (lo_drop !== 8'hFF) begin n_fail++; $display("FAIL sat_hold drop=%h exp ff", lo_drop); end
        req_in = 8'h00;
        step();
        n_checks++; if (lo_ovf !== 1'b0 || lo_drop !== 8'hFF) begin n_fail++; $display("FAIL sat_quiet ovf=%b drop=%h exp 0/ff", lo_ovf, lo_drop); end
        drain();
    endtask

    task automatic test_round_trip();
        logic [7:0] onehot;
        logic [7:0] dec_lo;
        logic [7:0] dec_hi;
        for (int i = 0; i < 8; i++) begin
            onehot    = 8'h01 << i;
            out_ready = 1'b1;
            req_in    = onehot;
            step();
            req_in = 8'h00;
            step();
            dec_lo = 8'h01 << lo_idx;
            dec_hi = 8'h01 << hi_idx;
            n_checks++; if (lo_valid !== 1'b1 || lo_idx !== 3'(i)) begin n_fail++; $display("FAIL rt_idx[%0d] valid=%b idx=%0d exp 1/%0d", i, lo_valid, lo_idx, i); end
            n_checks++; if (dec_lo !== onehot || dec_hi !== onehot) begin n_fail++; $display("FAIL rt_decode[%0d] got %h/%h exp %h", i, dec_lo, dec_hi, onehot); end
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid_handshake();
        test_multi_events();
        test_back_to_back();
        test_overflow();
        test_saturation();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
